sha256_w_sched_ctrl: RTL

Sequencer for the SHA-256 message-schedule datapath. It accepts one 512-bit padded block, holds the 16-word sliding window, and expands W[16..ROUNDS-1] with the σ0/σ1 recurrence. It streams W[0..ROUNDS-1] one word per accepted transfer to the compression-round engine under a valid/ready handshake. It sits between the block loader and the round core, and replaces the unrolled per-stage schedule memories where area matters more than throughput.

---
 rtl/sha256_w_sched_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sha256_w_sched_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_w_sched_ctrl
//   SHA-256 message-schedule sequencer. It loads one 512-bit padded block into
//   a 16-word sliding window. It then streams W[0..ROUNDS-1] to the round core,
//   one word per valid/ready transfer. Each transfer of W[t] also computes
//   W[t+16] into the top of the window.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   start      load request, honoured only while in_ready=1
//   block_in   message block, W0 = block_in[511:480] ... W15 = block_in[31:0]
//   abort      synchronous cancel of the current block
//   in_ready   1 while idle (ready to accept a block)
//   w_out      schedule word W[round_idx]
//   w_valid    w_out is valid
//   w_ready    consumer accepts w_out this cycle
//   round_idx  index of the word on w_out
//   done       one-cycle pulse after the last word is transferred
//   busy       1 while streaming
// ----------------------------------------------------------------------------
module sha256_w_sched_ctrl #(
    parameter int ROUNDS = 64          // legal range 17..64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         abort,
    output logic         in_ready,
    output logic [31:0]  w_out,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [5:0]   round_idx,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_window [16];
    logic [5:0]  r_round_idx;

    logic        w_load;
    logic        w_xfer;
    logic        w_last;
    logic        w_shift;
    logic [31:0] w_new_word;

    assign w_load  = (r_state == S_IDLE) && start && !abort;
    assign w_xfer  = (r_state == S_RUN) && w_ready;
    assign w_last  = (r_round_idx == LAST_IDX);
    // abort wins over a same-cycle transfer, and the final transfer leaves the
    // window and the index untouched.
    assign w_shift = w_xfer && !abort && !w_last;

    // Computes W[t+16] while W[t] (window[0]) is leaving. Additions wrap mod 2^32.
    assign w_new_word = sigma1(r_window[14]) + r_window[9]
                      + sigma0(r_window[1]) + r_window[0];

    // NOTE: next-state logic is purely combinational. The default assignment comes
    // first so that every path assigns w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_load) w_next_state = S_RUN;
            S_RUN: begin
                if (abort)                 w_next_state = S_IDLE;
                else if (w_xfer && w_last) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // NOTE: the window is a register file, but it is deliberately reset. Reset
    // must drive w_out (window[0]) to zero immediately, so every word is cleared.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < 16; k++) r_window[k] <= '0;
            r_round_idx <= '0;
        end else if (w_load) begin
            for (int k = 0; k < 16; k++) r_window[k] <= block_in[511 - 32*k -: 32];
            r_round_idx <= '0;
        end else if (w_shift) begin
            for (int k = 0; k < 15; k++) r_window[k] <= r_window[k + 1];
            r_window[15] <= w_new_word;
            r_round_idx  <= r_round_idx + 6'd1;
        end
    end

    // All outputs come straight from registers or from a state decode.
    assign in_ready  = (r_state == S_IDLE);
    assign w_valid   = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign w_out     = r_window[0];
    assign round_idx = r_round_idx;

endmodule
